// File: rtl/icache_pkg.sv
// Shared types and derived-width helpers for the burst instruction cache.
// Optional statistics counters are enabled with ICACHE_STATS_EN.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        READ,
        RESPOND
    } state_e;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

    function automatic int tag_bitwidth(int addr_w, int line_w, int word_w);
        return addr_w - line_w - word_w;
    endfunction

    function automatic int words_per_beat(int beat_w, int data_w);
        return beat_w / data_w;
    endfunction

    // Widths at the default parameterisation
    localparam int TAG_BITWIDTH   = tag_bitwidth(12, 1, 3);
    localparam int WORDS_PER_BEAT = words_per_beat(64, 32);

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays: whole-beat write port and
// combinational single-word read port.
module icache_line_store #(
    parameter int LIX_W   = 1,
    parameter int DIX_W   = 3,
    parameter int TAG_W   = 8,
    parameter int DW      = 32,
    parameter int BEAT_DW = 64,
    parameter int BEAT_W  = 2,
    parameter int WPB     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LIX_W-1:0]   rd_line_i,
    input  logic [DIX_W-1:0]   rd_word_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [DW-1:0]      rd_data_o,
    input  logic               wr_en_i,
    input  logic [LIX_W-1:0]   wr_line_i,
    input  logic [BEAT_W-1:0]  wr_beat_i,
    input  logic [BEAT_DW-1:0] wr_data_i,
    input  logic               fill_i,
    input  logic [TAG_W-1:0]   fill_tag_i
);
    localparam int LINES = 1 << LIX_W;
    localparam int WORDS = 1 << DIX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [DW-1:0]    mem_q [LINES][WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[wr_line_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[wr_line_i] <= fill_tag_i;
        end
        // Little-endian: low word of the beat lands at the lower word index
        if (wr_en_i) begin
            for (int w = 0; w < WPB; w++) begin
                mem_q[wr_line_i][DIX_W'(int'(wr_beat_i) * WPB + w)]
                    <= wr_data_i[w*DW +: DW];
            end
        end
    end

    assign rd_valid_o = valid_q[rd_line_i];
    assign rd_tag_o   = tag_q[rd_line_i];
    assign rd_data_o  = mem_q[rd_line_i][rd_word_i];

endmodule

// File: rtl/burst_icache.sv
// Direct-mapped read-only instruction cache filled by single-burst reads.
// Define ICACHE_STATS_EN to add hit_count / miss_count outputs.
module burst_icache
    import icache_pkg::*;
#(
    parameter int LINE_IX_BITWIDTH         = 1,
    parameter int ADDRESS_BITWIDTH         = 12,
    parameter int DATA_BITWIDTH            = 32,
    parameter int DATA_IX_IN_LINE_BITWIDTH = 3,
    parameter int RAM_DEPTH_BITWIDTH       = 4,
    parameter int RAM_BURST_DATA_BITWIDTH  = 64,
    parameter int RAM_BURST_DATA_COUNT     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic [ADDRESS_BITWIDTH-1:0]        address,
    output logic [DATA_BITWIDTH-1:0]           data,
    output logic                               data_ready,
    output logic                               busy,
    output logic                               br_cmd,
    output logic                               br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]      br_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
    input  logic                               br_rd_data_valid,
    input  logic                               br_busy
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                        hit_count,
    output logic [31:0]                        miss_count
`endif
);
    localparam int AW     = ADDRESS_BITWIDTH;
    localparam int DIX_W  = DATA_IX_IN_LINE_BITWIDTH;
    localparam int LIX_W  = LINE_IX_BITWIDTH;
    localparam int RDW    = RAM_DEPTH_BITWIDTH;
    localparam int TAG_W  = tag_bitwidth(AW, LIX_W, DIX_W);
    localparam int WPB    = words_per_beat(RAM_BURST_DATA_BITWIDTH, DATA_BITWIDTH);
    localparam int BEAT_W = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;

    state_e                   state_q, state_d;
    logic [AW-1:0]            addr_q, addr_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [DATA_BITWIDTH-1:0] data_q, data_d;
    logic                     data_ready_q, data_ready_d;
    logic                     br_cmd_en_q, br_cmd_en_d;
    logic [RDW-1:0]           br_addr_q, br_addr_d;

    logic [AW-1:0]            rd_addr;
    logic                     rd_valid;
    logic [TAG_W-1:0]         rd_tag;
    logic [DATA_BITWIDTH-1:0] rd_word;
    logic                     hit;
    logic                     wr_en;
    logic                     fill;

    // Lookups use the live address in IDLE, the latched one otherwise
    assign rd_addr = (state_q == IDLE) ? address : addr_q;
    assign hit     = rd_valid && (rd_tag == rd_addr[DIX_W+LIX_W +: TAG_W]);

    icache_line_store #(
        .LIX_W   (LIX_W),
        .DIX_W   (DIX_W),
        .TAG_W   (TAG_W),
        .DW      (DATA_BITWIDTH),
        .BEAT_DW (RAM_BURST_DATA_BITWIDTH),
        .BEAT_W  (BEAT_W),
        .WPB     (WPB)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_line_i  (rd_addr[DIX_W +: LIX_W]),
        .rd_word_i  (rd_addr[DIX_W-1:0]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_word),
        .wr_en_i    (wr_en),
        .wr_line_i  (addr_q[DIX_W +: LIX_W]),
        .wr_beat_i  (beat_q),
        .wr_data_i  (br_rd_data),
        .fill_i     (fill),
        .fill_tag_i (addr_q[DIX_W+LIX_W +: TAG_W])
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_d       = beat_q;
        data_d       = data_q;
        data_ready_d = 1'b0;
        br_cmd_en_d  = 1'b0;
        br_addr_d    = br_addr_q;
        wr_en        = 1'b0;
        fill         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    addr_d = address;
                    if (hit) begin
                        data_d       = rd_word;
                        data_ready_d = 1'b1;
                    end else begin
                        state_d = CMD;
                    end
                end
            end
            CMD: begin
                if (!br_busy) begin
                    br_cmd_en_d = 1'b1;
                    // Truncating before the multiply keeps the result mod 2^RDW
                    br_addr_d   = RDW'(addr_q[AW-1:DIX_W]) * RDW'(RAM_BURST_DATA_COUNT);
                    beat_d      = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                if (br_rd_data_valid) begin
                    wr_en  = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(RAM_BURST_DATA_COUNT - 1)) begin
                        fill    = 1'b1;
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                data_d       = rd_word;
                data_ready_d = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            data_q       <= '0;
            data_ready_q <= 1'b0;
            br_cmd_en_q  <= 1'b0;
            br_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            data_q       <= data_d;
            data_ready_q <= data_ready_d;
            br_cmd_en_q  <= br_cmd_en_d;
            br_addr_q    <= br_addr_d;
        end
    end

    assign data       = data_q;
    assign data_ready = data_ready_q;
    assign busy       = (state_q != IDLE);
    assign br_cmd     = BR_CMD_READ;
    assign br_cmd_en  = br_cmd_en_q;
    assign br_addr    = br_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (enable && state_q == IDLE) begin
            if (hit) hit_q <= hit_q + 32'd1;
            else     miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_burst_icache.sv
// Scoreboard bench for burst_icache: reference cache/RAM model in queues,
// monitor checks every data_ready and br_cmd_en against expectations.
module tb_burst_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [11:0] address;
    logic [31:0] data;
    logic        data_ready;
    logic        busy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [3:0]  br_addr;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    always #5 clk = ~clk;

    burst_icache dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .address          (address),
        .data             (data),
        .data_ready       (data_ready),
        .busy             (busy),
        .br_cmd           (br_cmd),
        .br_cmd_en        (br_cmd_en),
        .br_addr          (br_addr),
        .br_rd_data       (br_rd_data),
        .br_rd_data_valid (br_rd_data_valid),
        .br_busy          (br_busy)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [3:0]  expbr_q[$];
    int          resp_cnt = 0;
    int          issued   = 0;
    int          cmd_cnt  = 0;
    int          beats_sent = 0;
    int          gap_max  = 0;
    bit          ram_abort = 1'b0;

    // Reference model: 2 lines, tag = addr[11:4], line = addr[3]
    bit          m_valid[2];
    logic [7:0]  m_tag[2];
    int          m_hits = 0;
    int          m_misses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM holds 16 beats = 32 words; word i contains value i
    function automatic logic [31:0] ram_word(input int wix);
        return 32'(wix % 32);
    endfunction

    function automatic logic [3:0] burst_of(input logic [11:0] a);
        return 4'((int'(a) / 8) * 4 % 16);
    endfunction

    function automatic logic [31:0] expect_data(input logic [11:0] a);
        return ram_word(int'(burst_of(a)) * 2 + int'(a) % 8);
    endfunction

    // Monitor
    logic last_brb = 1'b0;
    logic prev_cmd_en = 1'b0;

    always @(posedge clk) last_brb <= br_busy;

    always @(negedge clk) begin
        if (data_ready) begin
            resp_cnt++;
            if (exp_q.size() == 0) check("unexpected data_ready", 1, 0);
            else check("data", data, exp_q.pop_front());
        end
        if (br_cmd_en) begin
            cmd_cnt++;
            check("br_cmd", br_cmd, 0);
            check("cmd while br_busy", last_brb, 0);
            check("cmd_en pulse width", prev_cmd_en, 0);
            if (expbr_q.size() == 0) check("unexpected br_cmd_en", 1, 0);
            else check("br_addr", br_addr, expbr_q.pop_front());
        end
        prev_cmd_en <= br_cmd_en;
    end

    // Burst-RAM responder
    initial begin
        br_rd_data_valid = 1'b0;
        br_rd_data = '0;
        forever begin
            @(negedge clk);
            if (br_cmd_en) begin
                int base;
                base = int'(br_addr);
                beats_sent = 0;
                for (int k = 0; k < 4; k++) begin
                    int g;
                    int wix;
                    g = $urandom_range(0, gap_max);
                    repeat (g) @(negedge clk);
                    if (ram_abort) break;
                    wix = ((base + k) % 16) * 2;
                    br_rd_data = {ram_word(wix + 1), ram_word(wix)};
                    br_rd_data_valid = 1'b1;
                    @(negedge clk);
                    br_rd_data_valid = 1'b0;
                    beats_sent++;
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("busy timeout", 1, 0);
    endtask

    task automatic wait_resp();
        int t = 0;
        while (resp_cnt < issued && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            check("response timeout", resp_cnt, issued);
            issued = resp_cnt;
            exp_q.delete();
            expbr_q.delete();
        end
    endtask

    task automatic request(input logic [11:0] a, input bit poke);
        int  ln;
        bit  h;
        wait_idle();
        ln = int'(a[3]);
        h  = m_valid[ln] && (m_tag[ln] == a[11:4]);
        exp_q.push_back(expect_data(a));
        if (h) begin
            m_hits++;
        end else begin
            m_misses++;
            expbr_q.push_back(burst_of(a));
            m_valid[ln] = 1'b1;
            m_tag[ln] = a[11:4];
        end
        issued++;
        beats_sent = 0;
        enable = 1'b1;
        address = a;
        @(negedge clk);
        enable = 1'b0;
        if (h) begin
            check("hit latency", data_ready, 1);
            check("busy on hit", busy, 0);
        end else begin
            check("busy after miss", busy, 1);
            if (poke) begin
                enable = 1'b1;
                address = a ^ 12'h008;
                @(negedge clk);
                enable = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        address = '0;
        br_busy = 1'b0;
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset data", data, 0);
        check("reset data_ready", data_ready, 0);
        check("reset busy", busy, 0);
        check("reset br_cmd", br_cmd, 0);
        check("reset br_cmd_en", br_cmd_en, 0);
        check("reset br_addr", br_addr, 0);
`ifdef ICACHE_STATS_EN
        check("reset hit_count", hit_count, 0);
        check("reset miss_count", miss_count, 0);
`endif

        // Directed walk through the basic hit/miss/replace cases
        request(12'd0, 1'b0);  wait_resp();
        request(12'd5, 1'b0);  wait_resp();
        request(12'd8, 1'b0);  wait_resp();
        request(12'd0, 1'b0);  wait_resp();
        request(12'd16, 1'b0); wait_resp();
        request(12'd0, 1'b1);  wait_resp();

        // br_busy held high across a miss
        begin
            int c0;
            br_busy = 1'b1;
            c0 = cmd_cnt;
            request(12'd24, 1'b0);
            repeat (5) @(negedge clk);
            check("no cmd while br_busy", cmd_cnt, c0);
            br_busy = 1'b0;
            wait_resp();
            check("cmd after br_busy falls", cmd_cnt, c0 + 1);
        end

        // Gaps between beats
        gap_max = 3;
        request(12'd21, 1'b0); wait_resp();

        // Reset in the middle of a fill
        begin
            int t = 0;
            request(12'd3, 1'b0);
            while (beats_sent < 2 && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) check("beat wait timeout", 1, 0);
            rst = 1'b1;
            ram_abort = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("busy after mid-fill rst", busy, 0);
            check("data_ready after mid-fill rst", data_ready, 0);
            exp_q.delete();
            expbr_q.delete();
            issued = resp_cnt;
            m_valid[0] = 1'b0;
            m_valid[1] = 1'b0;
            m_hits = 0;
            m_misses = 0;
            repeat (8) @(negedge clk);
            ram_abort = 1'b0;
            request(12'd3, 1'b0); wait_resp();
        end

        // Randomised traffic with random br_busy stalls
        for (int i = 0; i < 80; i++) begin
            logic [11:0] a;
            if ($urandom_range(0, 9) == 0) a = 12'($urandom_range(0, 4095));
            else a = 12'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(1, 6);
                br_busy = 1'b1;
                fork
                    begin
                        repeat (n) @(negedge clk);
                        br_busy = 1'b0;
                    end
                join_none
            end
            request(a, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) wait_resp();
        end
        wait_resp();
        repeat (10) @(negedge clk);
        br_busy = 1'b0;

        check("leftover expected data", exp_q.size(), 0);
        check("leftover expected cmds", expbr_q.size(), 0);
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
